// File: rtl/issue_scheduler_if.sv
// -----------------------------------------------------------------------------
// issue_scheduler_if
// Handshake bundle between the three instruction queues / execution units
// and the issue scheduler.
//   *_empty          queue empty flags            (queue  -> scheduler)
//   *_unit_ready     unit can accept next cycle   (unit   -> scheduler)
//   dma_done         one-cycle DMA completion     (DMA    -> scheduler)
//   *_re             queue read enables           (scheduler -> queue)
//   *_issue_valid    queue output valid for unit  (scheduler -> unit)
// master: queue/unit side, slave: scheduler side.
// -----------------------------------------------------------------------------
interface issue_scheduler_if;
    logic dma_empty;
    logic arith_empty;
    logic cache_empty;
    logic dma_unit_ready;
    logic arith_unit_ready;
    logic cache_unit_ready;
    logic dma_done;
    logic dma_re;
    logic arith_re;
    logic cache_re;
    logic dma_issue_valid;
    logic arith_issue_valid;
    logic cache_issue_valid;

    modport master (
        output dma_empty, arith_empty, cache_empty,
        output dma_unit_ready, arith_unit_ready, cache_unit_ready,
        output dma_done,
        input  dma_re, arith_re, cache_re,
        input  dma_issue_valid, arith_issue_valid, cache_issue_valid
    );

    modport slave (
        input  dma_empty, arith_empty, cache_empty,
        input  dma_unit_ready, arith_unit_ready, cache_unit_ready,
        input  dma_done,
        output dma_re, arith_re, cache_re,
        output dma_issue_valid, arith_issue_valid, cache_issue_valid
    );
endinterface

// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
// Decides each cycle which instruction queues to pop (DMA, arithmetic,
// regfile/cache) and flags the matching unit one cycle later. Arith and cache
// share one SRAM port and are round-robin arbitrated; DMA issue is limited by
// an outstanding-transfer credit counter. A drain handshake quiesces issue.
// Ports:
//   clk              clock, all state on posedge
//   reset            asynchronous, active-low
//   q                queue/unit handshake bundle (slave side)
//   drain_req        level request to stop issuing
//   dma_outstanding  DMA transfers in flight
//   drained          high while fully quiesced
//   stall_cycles     saturating count of RUN cycles with work but no issue
// -----------------------------------------------------------------------------
module issue_scheduler #(
    parameter int MAX_OUTSTANDING_DMA = 4,
    parameter int LOG_MAX_OUTSTANDING = 2,
    parameter int STALL_COUNTER_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    issue_scheduler_if.slave               q,
    input  logic                           drain_req,
    output logic [LOG_MAX_OUTSTANDING:0]   dma_outstanding,
    output logic                           drained,
    output logic [STALL_COUNTER_WIDTH-1:0] stall_cycles
);
    localparam int CNT_W = LOG_MAX_OUTSTANDING + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING_DMA);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DRAINED} state_t;

    state_t                         state_reg, state_next;
    logic [CNT_W-1:0]               outstanding_reg, outstanding_next;
    logic [STALL_COUNTER_WIDTH-1:0] stall_reg, stall_next;
    logic                           prio_reg, prio_next;
    logic                           issue_valid_reg [3];   // 0 dma, 1 arith, 2 cache
    logic [2:0]                     re_vec;

    logic run_active;
    logic dma_grant, arith_grant, cache_grant;
    logic arith_elig, cache_elig;
    logic any_issue_valid;
    logic any_nonempty;

    // Next state and read enables. Gating with reset keeps every re low while
    // reset is held, independent of the (already cleared) state register.
    always_comb begin
        state_next  = state_reg;
        run_active  = reset && (state_reg == ST_RUN);
        // Credit check uses the registered count; a same-cycle dma_done only
        // frees a credit from the next cycle on.
        dma_grant   = run_active && !q.dma_empty && q.dma_unit_ready
                      && (outstanding_reg < MAX_CNT);
        arith_elig  = run_active && !q.arith_empty && q.arith_unit_ready;
        cache_elig  = run_active && !q.cache_empty && q.cache_unit_ready;
        // prio: 0 favours arith, 1 favours cache when both contend.
        arith_grant = arith_elig && (!cache_elig || !prio_reg);
        cache_grant = cache_elig && (!arith_elig || prio_reg);

        unique case (state_reg)
            ST_RUN: begin
                if (drain_req) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Quiesced wins over a simultaneous drain_req drop.
                if (outstanding_reg == '0 && !any_issue_valid)
                    state_next = ST_DRAINED;
                else if (!drain_req)
                    state_next = ST_RUN;
            end
            ST_DRAINED: begin
                if (!drain_req) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Counter / pointer next values.
    always_comb begin
        outstanding_next = outstanding_reg;
        stall_next       = stall_reg;
        prio_next        = prio_reg;

        if (dma_grant && !q.dma_done)
            outstanding_next = outstanding_reg + CNT_W'(1);
        else if (!dma_grant && q.dma_done && outstanding_reg != '0)
            outstanding_next = outstanding_reg - CNT_W'(1);

        if (run_active && any_nonempty && !(dma_grant || arith_grant || cache_grant)
            && stall_reg != '1)
            stall_next = stall_reg + STALL_COUNTER_WIDTH'(1);

        if (arith_grant) prio_next = 1'b1;
        if (cache_grant) prio_next = 1'b0;
    end

    assign any_nonempty    = !q.dma_empty || !q.arith_empty || !q.cache_empty;
    assign any_issue_valid = issue_valid_reg[0] || issue_valid_reg[1] || issue_valid_reg[2];
    assign re_vec          = {cache_grant, arith_grant, dma_grant};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_RUN;
            outstanding_reg <= '0;
            stall_reg       <= '0;
            prio_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            outstanding_reg <= outstanding_next;
            stall_reg       <= stall_next;
            prio_reg        <= prio_next;
        end
    end

    // issue_valid is the re of the previous cycle: the queue output becomes
    // valid the cycle after the pop.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_issue_valid
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) issue_valid_reg[gi] <= 1'b0;
                else        issue_valid_reg[gi] <= re_vec[gi];
            end
        end
    endgenerate

    assign q.dma_re            = dma_grant;
    assign q.arith_re          = arith_grant;
    assign q.cache_re          = cache_grant;
    assign q.dma_issue_valid   = issue_valid_reg[0];
    assign q.arith_issue_valid = issue_valid_reg[1];
    assign q.cache_issue_valid = issue_valid_reg[2];
    assign dma_outstanding     = outstanding_reg;
    assign drained             = (state_reg == ST_DRAINED);
    assign stall_cycles        = stall_reg;
endmodule

// File: tb/tb_issue_scheduler.sv
// -----------------------------------------------------------------------------
// tb_issue_scheduler
// Scenario tasks plus a randomized run, each cycle compared against a
// behavioural model of the scheduling rules. The stall counter is built
// 4 bits wide so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_issue_scheduler;
    logic       clk = 1'b0;
    logic       reset;
    logic       drain_req;
    logic [2:0] dma_outstanding;
    logic       drained;
    logic [3:0] stall_cycles;

    always #5 clk = ~clk;

    issue_scheduler_if qif ();

    issue_scheduler #(
        .MAX_OUTSTANDING_DMA (4),
        .LOG_MAX_OUTSTANDING (2),
        .STALL_COUNTER_WIDTH (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .q               (qif),
        .drain_req       (drain_req),
        .dma_outstanding (dma_outstanding),
        .drained         (drained),
        .stall_cycles    (stall_cycles)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: mode 0 run, 1 draining, 2 drained.
    int       m_out, m_stall, m_mode;
    bit       m_prio;
    bit [2:0] m_iv;      // {dma, arith, cache} granted last cycle
    bit [2:0] m_grant;   // {dma, arith, cache} granted this cycle
    bit [13:0] m_exp;
    logic [13:0] obs;

    // Queue occupancy driven by the bench when use_q is set.
    int q_dma, q_ar, q_ca;
    bit use_q;

    function automatic logic [13:0] obs_vec();
        return {qif.dma_re, qif.arith_re, qif.cache_re,
                qif.dma_issue_valid, qif.arith_issue_valid, qif.cache_issue_valid,
                drained, dma_outstanding, stall_cycles};
    endfunction

    task automatic model_reset();
        m_out = 0; m_stall = 0; m_mode = 0; m_prio = 0; m_iv = 3'b000; m_grant = 3'b000;
    endtask

    task automatic set_idle();
        qif.dma_empty = 1; qif.arith_empty = 1; qif.cache_empty = 1;
        qif.dma_unit_ready = 0; qif.arith_unit_ready = 0; qif.cache_unit_ready = 0;
        qif.dma_done = 0; drain_req = 0;
    endtask

    task automatic step_begin();
        @(negedge clk);
        qif.dma_done = 0;
    endtask

    // Settle inputs, then work out what the rules demand for this cycle.
    task automatic step_eval();
        bit run, ae, ce;
        if (use_q) begin
            qif.dma_empty   = (q_dma == 0);
            qif.arith_empty = (q_ar == 0);
            qif.cache_empty = (q_ca == 0);
        end
        #1;
        run = (m_mode == 0);
        m_grant[2] = run && !qif.dma_empty && qif.dma_unit_ready && (m_out < 4);
        ae = run && !qif.arith_empty && qif.arith_unit_ready;
        ce = run && !qif.cache_empty && qif.cache_unit_ready;
        m_grant[1] = ae && (!ce || !m_prio);
        m_grant[0] = ce && (!ae || m_prio);
        m_exp = {m_grant, m_iv, (m_mode == 2), 3'(m_out), 4'(m_stall)};
    endtask

    task automatic step_end();
        int  new_mode;
        bit  any_ne;
        @(posedge clk);
        any_ne = !qif.dma_empty || !qif.arith_empty || !qif.cache_empty;
        new_mode = m_mode;
        if (m_mode == 0 && drain_req) new_mode = 1;
        else if (m_mode == 1 && m_out == 0 && m_iv == 0) new_mode = 2;
        else if (m_mode != 0 && !drain_req) new_mode = 0;
        if (m_mode == 0 && any_ne && m_grant == 0 && m_stall < 15) m_stall++;
        if (m_grant[2] && !qif.dma_done) m_out++;
        else if (!m_grant[2] && qif.dma_done && m_out > 0) m_out--;
        if (m_grant[1]) m_prio = 1;
        if (m_grant[0]) m_prio = 0;
        m_iv = m_grant;
        m_mode = new_mode;
        if (use_q) begin
            if (m_grant[2]) q_dma--;
            if (m_grant[1]) q_ar--;
            if (m_grant[0]) q_ca--;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 0;
        set_idle();
        use_q = 1; q_dma = 0; q_ar = 0; q_ca = 0;
        repeat (2) @(negedge clk);
        model_reset();
        #1 reset = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        qif.dma_empty = 0; qif.arith_empty = 0; qif.cache_empty = 0;
        qif.dma_unit_ready = 1; qif.arith_unit_ready = 1; qif.cache_unit_ready = 1;
        qif.dma_done = 0; drain_req = 0;
        repeat (2) @(negedge clk);
        #1;
        obs = obs_vec();
        checks++;
        if (obs !== 14'h0) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", obs, 14'h0);
        end
        apply_reset();
    endtask

    task automatic test_arbitration();
        string seq;
        apply_reset();
        q_ar = 3; q_ca = 3;
        qif.dma_unit_ready = 1; qif.arith_unit_ready = 1; qif.cache_unit_ready = 1;
        seq = "";
        for (int i = 0; i < 8; i++) begin
            step_begin(); step_eval();
            obs = obs_vec();
            checks++;
            if (obs !== m_exp) begin
                failures++;
                $display("FAIL arbitration cycle %0d: got %h expected %h", i, obs, m_exp);
            end
            if (qif.arith_re) seq = {seq, "A"};
            if (qif.cache_re) seq = {seq, "C"};
            step_end();
        end
        checks++;
        if (seq != "ACACAC") begin
            failures++;
            $display("FAIL arbitration_order: got %s expected ACACAC", seq);
        end
        checks++;
        if (stall_cycles !== 4'd0) begin
            failures++;
            $display("FAIL arbitration_stall: got %0d expected 0", stall_cycles);
        end
        $display("arbitration: grant order %s", seq);
    endtask

    task automatic test_dma_credit();
        int n_re;
        apply_reset();
        q_dma = 6;
        qif.dma_unit_ready = 1;
        n_re = 0;
        for (int i = 0; i < 6; i++) begin
            step_begin(); step_eval();
            obs = obs_vec();
            checks++;
            if (obs !== m_exp) begin
                failures++;
                $display("FAIL dma_credit cycle %0d: got %h expected %h", i, obs, m_exp);
            end
            if (qif.dma_re) n_re++;
            step_end();
        end
        checks++;
        if (n_re != 4 || dma_outstanding !== 3'd4) begin
            failures++;
            $display("FAIL dma_credit_limit: got re=%0d outstanding=%0d expected re=4 outstanding=4",
                     n_re, dma_outstanding);
        end
        for (int i = 0; i < 3; i++) begin
            step_begin();
            qif.dma_done = (i == 0);
            step_eval();
            obs = obs_vec();
            checks++;
            if (obs !== m_exp) begin
                failures++;
                $display("FAIL dma_credit_resume cycle %0d: got %h expected %h", i, obs, m_exp);
            end
            step_end();
        end
        checks++;
        if (dma_outstanding !== 3'd4) begin
            failures++;
            $display("FAIL dma_credit_refill: got %0d expected 4", dma_outstanding);
        end
        $display("dma_credit: %0d re before limit, outstanding %0d", n_re, dma_outstanding);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        q_dma = 2;
        qif.dma_unit_ready = 1;
        // issue 2, then dma_re together with dma_done, then 2 dones, then a stray done
        for (int i = 0; i < 7; i++) begin
            step_begin();
            if (i == 2) q_dma = 1;
            qif.dma_done = (i >= 2 && i != 3);
            step_eval();
            obs = obs_vec();
            checks++;
            if (obs !== m_exp) begin
                failures++;
                $display("FAIL simultaneous cycle %0d: got %h expected %h", i, obs, m_exp);
            end
            step_end();
            if (i == 2) begin
                #1;
                checks++;
                if (dma_outstanding !== 3'd2) begin
                    failures++;
                    $display("FAIL sim_re_and_done: got %0d expected 2", dma_outstanding);
                end
            end
        end
        #1;
        checks++;
        if (dma_outstanding !== 3'd0) begin
            failures++;
            $display("FAIL sim_no_underflow: got %0d expected 0", dma_outstanding);
        end
        $display("simultaneous: outstanding %0d after stray done", dma_outstanding);
    endtask

    task automatic test_drain();
        int n_re_after;
        apply_reset();
        q_dma = 2;
        qif.dma_unit_ready = 1; qif.arith_unit_ready = 1; qif.cache_unit_ready = 1;
        n_re_after = 0;
        for (int i = 0; i < 16; i++) begin
            step_begin();
            if (i == 2) drain_req = 1;
            if (i == 3) begin q_dma = 5; q_ar = 5; q_ca = 5; end
            qif.dma_done = (i == 5 || i == 7);
            if (i == 12) drain_req = 0;
            step_eval();
            obs = obs_vec();
            checks++;
            if (obs !== m_exp) begin
                failures++;
                $display("FAIL drain cycle %0d: got %h expected %h", i, obs, m_exp);
            end
            if (i == 11) begin
                checks++;
                if (drained !== 1'b1) begin
                    failures++;
                    $display("FAIL drain_reached: got %b expected 1", drained);
                end
            end
            if (i >= 13 && (qif.dma_re || qif.arith_re || qif.cache_re)) n_re_after++;
            step_end();
        end
        checks++;
        if (n_re_after == 0 || drained !== 1'b0) begin
            failures++;
            $display("FAIL drain_resume: got re_count=%0d drained=%b expected re_count>0 drained=0",
                     n_re_after, drained);
        end
        $display("drain: %0d issues after release", n_re_after);
    endtask

    task automatic test_stall();
        apply_reset();
        q_ar = 5;
        for (int i = 0; i < 20; i++) begin
            step_begin(); step_eval();
            obs = obs_vec();
            checks++;
            if (obs !== m_exp) begin
                failures++;
                $display("FAIL stall cycle %0d: got %h expected %h", i, obs, m_exp);
            end
            step_end();
            if (i == 4) begin
                #1;
                checks++;
                if (stall_cycles !== 4'd5) begin
                    failures++;
                    $display("FAIL stall_count: got %0d expected 5", stall_cycles);
                end
            end
        end
        #1;
        checks++;
        if (stall_cycles !== 4'hF) begin
            failures++;
            $display("FAIL stall_saturate: got %0d expected 15", stall_cycles);
        end
        $display("stall: counter %0d", stall_cycles);
    endtask

    task automatic test_random();
        apply_reset();
        use_q = 0;
        for (int i = 0; i < 400; i++) begin
            step_begin();
            qif.dma_empty   = ($urandom_range(0, 3) == 0);
            qif.arith_empty = ($urandom_range(0, 3) == 0);
            qif.cache_empty = ($urandom_range(0, 3) == 0);
            qif.dma_unit_ready   = ($urandom_range(0, 3) != 0);
            qif.arith_unit_ready = ($urandom_range(0, 3) != 0);
            qif.cache_unit_ready = ($urandom_range(0, 3) != 0);
            qif.dma_done = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
            step_eval();
            obs = obs_vec();
            checks++;
            if (obs !== m_exp) begin
                failures++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, m_exp);
            end
            step_end();
        end
        use_q = 1;
        $display("random: 400 cycles compared");
    endtask

    task automatic test_async_reset();
        apply_reset();
        q_dma = 5; q_ar = 5;
        qif.dma_unit_ready = 1; qif.arith_unit_ready = 1; qif.cache_unit_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step_begin(); step_eval();
            obs = obs_vec();
            checks++;
            if (obs !== m_exp) begin
                failures++;
                $display("FAIL async_burst cycle %0d: got %h expected %h", i, obs, m_exp);
            end
            step_end();
        end
        // mid-cycle, with re high and outstanding=3
        step_begin(); step_eval();
        reset = 0;
        #1;
        obs = obs_vec();
        checks++;
        if (obs !== 14'h0) begin
            failures++;
            $display("FAIL async_reset_clear: got %h expected %h", obs, 14'h0);
        end
        @(negedge clk);
        set_idle();
        model_reset();
        q_dma = 0; q_ar = 1; q_ca = 1;
        #1 reset = 1;
        qif.arith_unit_ready = 1; qif.cache_unit_ready = 1;
        step_begin(); step_eval();
        obs = obs_vec();
        checks++;
        if (obs !== m_exp || !(qif.arith_re === 1'b1 && qif.cache_re === 1'b0)) begin
            failures++;
            $display("FAIL async_first_grant: got %h expected %h (arith first)", obs, m_exp);
        end
        step_end();
        $display("async_reset: first contended grant checked");
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_dma_credit();
        test_simultaneous();
        test_drain();
        test_stall();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
